// File: rtl/life_engine_gen_pkg.sv
// Shared types, state encodings and cell-index helpers for the Game-of-Life engine.
package life_engine_gen_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [8:0] RULE_B_DEFAULT = 9'b000001000;
  localparam logic [8:0] RULE_S_DEFAULT = 9'b000001100;

  // One request wins per IDLE cycle; the others are dropped.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_STEP = 2'd1,
    CMD_FLIP = 2'd2,
    CMD_LOAD = 2'd3
  } idle_cmd_e;

  function automatic int cell_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

  function automatic int idx_x(input int idx, input int w);
    return idx % w;
  endfunction

  function automatic int idx_y(input int idx, input int w);
    return idx / w;
  endfunction

endpackage

// File: rtl/life_engine_gen_if.sv
// Control/edit/display bundle between the key/cursor logic, the engine and the row display.
interface life_engine_gen_if #(
  parameter int X     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GEN_W = 16
);
  logic             wrap;
  logic             step_req;
  logic             load_valid;
  logic             load_bit;
  logic             flip_req;
  logic [LOG2X-1:0] flip_x;
  logic [LOG2Y-1:0] flip_y;
  logic [LOG2Y-1:0] row_sel;
  logic [X-1:0]     row;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_cnt;
  logic             extinct;
  logic             stable;

  modport master (
    output wrap, step_req, load_valid, load_bit, flip_req, flip_x, flip_y, row_sel,
    input  row, busy, done, gen_cnt, extinct, stable
  );

  modport slave (
    input  wrap, step_req, load_valid, load_bit, flip_req, flip_x, flip_y, row_sel,
    output row, busy, done, gen_cnt, extinct, stable
  );
endinterface

// File: rtl/life_engine_gen_next_cell.sv
// Next-generation value of one cell: neighbour fetch with optional toroidal wrap,
// neighbour popcount and birth/survive rule lookup. Purely combinational.
module life_next_cell
  import life_engine_gen_pkg::*;
#(
  parameter int         X      = 8,
  parameter int         Y      = 8,
  parameter int         LOG2X  = 3,
  parameter int         LOG2Y  = 3,
  parameter logic [8:0] RULE_B = RULE_B_DEFAULT,
  parameter logic [8:0] RULE_S = RULE_S_DEFAULT
) (
  input  logic [X*Y-1:0]   board_i,
  input  logic [LOG2X-1:0] x_i,
  input  logic [LOG2Y-1:0] y_i,
  input  logic             wrap_i,
  output logic             next_o
);

  localparam int IW = (X * Y > 1) ? $clog2(X * Y) : 1;

  logic [3:0] count;
  logic       live;

  always_comb begin
    int   nx;
    int   ny;
    logic inb;
    nx    = 0;
    ny    = 0;
    inb   = 1'b0;
    count = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx  = int'(x_i) + dx;
        ny  = int'(y_i) + dy;
        inb = 1'b1;
        // Off-board neighbours either wrap to the far edge or read as dead.
        if (nx < 0) begin
          nx  = X - 1;
          inb = wrap_i;
        end else if (nx >= X) begin
          nx  = 0;
          inb = wrap_i;
        end
        if (ny < 0) begin
          ny  = Y - 1;
          inb = inb & wrap_i;
        end else if (ny >= Y) begin
          ny  = 0;
          inb = inb & wrap_i;
        end
        if (!(dx == 0 && dy == 0) && inb && board_i[IW'(cell_idx(nx, ny, X))]) begin
          count = count + 4'd1;
        end
      end
    end
  end

  assign live   = board_i[IW'(cell_idx(int'(x_i), int'(y_i), X))];
  assign next_o = live ? RULE_S[count] : RULE_B[count];

endmodule

// File: rtl/life_engine_gen.sv
// Game-of-Life generation engine: X*Y board, one cell evaluated per clock,
// serial load, single-cell edit, generation counter and extinct/stable flags.
//
//   state   | meaning
//   IDLE    | accept step / flip / load (in that priority)
//   COMPUTE | evaluate cell (cx,cy) into the next buffer, raster order
//   COMMIT  | copy next buffer to board, update counter and flags
module life_engine_gen
  import life_engine_gen_pkg::*;
#(
  parameter int         X      = 8,
  parameter int         Y      = 8,
  parameter int         LOG2X  = 3,
  parameter int         LOG2Y  = 3,
  parameter logic [8:0] RULE_B = RULE_B_DEFAULT,
  parameter logic [8:0] RULE_S = RULE_S_DEFAULT,
  parameter int         GEN_W  = 16
) (
  input logic              clk,
  input logic              reset,
  life_engine_gen_if.slave bus
);

  localparam int N  = X * Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]       state_q, state_d;
  logic [LOG2X-1:0] cx_q, cx_d;
  logic [LOG2Y-1:0] cy_q, cy_d;
  logic [N-1:0]     board_q, board_d;
  logic [N-1:0]     next_q, next_d;
  logic [X-1:0]     row_q, row_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d;
  logic             extinct_q, extinct_d;
  logic             stable_q, stable_d;

  idle_cmd_e        cmd;
  logic             flip_ok;
  logic [IW-1:0]    flip_idx;
  logic [IW-1:0]    cur_idx;
  logic             last_cell;
  logic             next_bit;

  always_comb begin
    cmd = CMD_NONE;
    if (bus.step_req) begin
      cmd = CMD_STEP;
    end else if (bus.flip_req) begin
      cmd = CMD_FLIP;
    end else if (bus.load_valid) begin
      cmd = CMD_LOAD;
    end
  end

  // Edit coordinates may exceed the board when X or Y is not a power of two.
  assign flip_ok   = (int'(bus.flip_x) < X) && (int'(bus.flip_y) < Y);
  assign flip_idx  = IW'(cell_idx(int'(bus.flip_x), int'(bus.flip_y), X));
  assign cur_idx   = IW'(cell_idx(int'(cx_q), int'(cy_q), X));
  assign last_cell = (int'(cx_q) == X - 1) && (int'(cy_q) == Y - 1);

  life_next_cell #(
    .X      (X),
    .Y      (Y),
    .LOG2X  (LOG2X),
    .LOG2Y  (LOG2Y),
    .RULE_B (RULE_B),
    .RULE_S (RULE_S)
  ) u_next_cell (
    .board_i (board_q),
    .x_i     (cx_q),
    .y_i     (cy_q),
    .wrap_i  (bus.wrap),
    .next_o  (next_bit)
  );

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    board_d   = board_q;
    next_d    = next_q;
    gen_d     = gen_q;
    done_d    = 1'b0;
    extinct_d = extinct_q;
    stable_d  = stable_q;
    case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_STEP: begin
            state_d = ST_COMPUTE;
            cx_d    = '0;
            cy_d    = '0;
          end
          CMD_FLIP: begin
            if (flip_ok) begin
              board_d[flip_idx] = ~board_q[flip_idx];
            end
          end
          CMD_LOAD: begin
            board_d = {bus.load_bit, board_q[N-1:1]};
          end
          default: begin
          end
        endcase
      end
      ST_COMPUTE: begin
        // The board stays untouched here so every cell sees the same generation.
        next_d[cur_idx] = next_bit;
        if (last_cell) begin
          state_d = ST_COMMIT;
        end else if (int'(cx_q) == X - 1) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        board_d   = next_q;
        stable_d  = (next_q == board_q);
        extinct_d = (next_q == '0);
        gen_d     = gen_q + 1'b1;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    row_d = '0;
    if (int'(bus.row_sel) < Y) begin
      row_d = board_q[IW'(cell_idx(0, int'(bus.row_sel), X)) +: X];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      board_q   <= '0;
      next_q    <= '0;
      row_q     <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      extinct_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      board_q   <= board_d;
      next_q    <= next_d;
      row_q     <= row_d;
      gen_q     <= gen_d;
      done_q    <= done_d;
      extinct_q <= extinct_d;
      stable_q  <= stable_d;
    end
  end

  assign bus.row     = row_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.gen_cnt = gen_q;
  assign bus.extinct = extinct_q;
  assign bus.stable  = stable_q;

endmodule

// File: tb/tb_life_engine_gen.sv
// Bench for life_engine_gen: an 8x8 B3/S23 instance and a 6x5 B3/S instance driven
// from shared stimulus, checked each cycle against a board-level behavioural model.
module tb_life_engine_gen;

  localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] GLIDER0  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GLIDER4  = 64'h0000_0000_0E08_0400;
  localparam logic [63:0] BLOCK0   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] CORNERS  = 64'h8100_0000_0000_0081;
  localparam logic [63:0] CELL55   = 64'h0000_2000_0000_0000;
  localparam logic [63:0] SMALL_BL = 64'h0000_0000_0010_4100;
  localparam logic [63:0] SMALL_G1 = 64'h0000_0000_0000_A000;
  localparam logic [63:0] SMALL_WR = 64'h0000_0000_0004_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wrap, step_req, load_valid, load_bit, flip_req;
  logic [2:0] flip_x, flip_y, row_sel;

  life_engine_gen_if #(.X(8), .LOG2X(3), .LOG2Y(3), .GEN_W(16)) if8 ();
  life_engine_gen_if #(.X(6), .LOG2X(3), .LOG2Y(3), .GEN_W(16)) if6 ();

  assign if8.wrap = wrap;        assign if6.wrap = wrap;
  assign if8.step_req = step_req; assign if6.step_req = step_req;
  assign if8.load_valid = load_valid; assign if6.load_valid = load_valid;
  assign if8.load_bit = load_bit; assign if6.load_bit = load_bit;
  assign if8.flip_req = flip_req; assign if6.flip_req = flip_req;
  assign if8.flip_x = flip_x;     assign if6.flip_x = flip_x;
  assign if8.flip_y = flip_y;     assign if6.flip_y = flip_y;
  assign if8.row_sel = row_sel;   assign if6.row_sel = row_sel;

  life_engine_gen #(
    .X(8), .Y(8), .LOG2X(3), .LOG2Y(3),
    .RULE_B(9'b000001000), .RULE_S(9'b000001100), .GEN_W(16)
  ) u_dut8 (.clk(clk), .reset(rst), .bus(if8));

  life_engine_gen #(
    .X(6), .Y(5), .LOG2X(3), .LOG2Y(3),
    .RULE_B(9'h008), .RULE_S(9'h000), .GEN_W(16)
  ) u_dut6 (.clk(clk), .reset(rst), .bus(if6));

  int checks = 0;
  int failures = 0;
  bit sel6 = 1'b0;
  bit cmp_en = 1'b0;

  int          mw = 8, mh = 8;
  logic [8:0]  mrb = 9'b000001000, mrs = 9'b000001100;
  logic [63:0] m_board = '0;
  int          m_left = 0;
  logic        m_done = 1'b0, m_ext = 1'b0, m_stab = 1'b0;
  logic [15:0] m_gen = '0;
  logic [7:0]  m_row = '0;

  logic [7:0]  d_row;
  logic        d_busy, d_done, d_ext, d_stab;
  logic [15:0] d_gen;

  assign d_row  = sel6 ? {2'b00, if6.row} : if8.row;
  assign d_busy = sel6 ? if6.busy : if8.busy;
  assign d_done = sel6 ? if6.done : if8.done;
  assign d_ext  = sel6 ? if6.extinct : if8.extinct;
  assign d_stab = sel6 ? if6.stable : if8.stable;
  assign d_gen  = sel6 ? if6.gen_cnt : if8.gen_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-board successor straight from the rules: count the eight neighbours of every cell.
  function automatic logic [63:0] life_step(input logic [63:0] b, input int w, input int h,
                                            input bit wr, input logic [8:0] rb,
                                            input logic [8:0] rs);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx, yy;
            xx = x + dx;
            yy = y + dy;
            if (dx != 0 || dy != 0) begin
              if (wr) begin
                xx = (xx + w) % w;
                yy = (yy + h) % h;
                n += int'(b[yy * w + xx]);
              end else if (xx >= 0 && xx < w && yy >= 0 && yy < h) begin
                n += int'(b[yy * w + xx]);
              end
            end
          end
        end
        r[y * w + x] = b[y * w + x] ? rs[n] : rb[n];
      end
    end
    return r;
  endfunction

  // Cycle model: remaining busy cycles, board, counter and flags per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      begin
        logic [7:0]  nr;
        logic [63:0] nb;
        nr = '0;
        if (int'(row_sel) < mh)
          for (int i = 0; i < mw; i++) nr[i] = m_board[int'(row_sel) * mw + i];
        if (rst !== 1'b1) begin
          m_board = '0; m_left = 0; m_done = 1'b0; m_ext = 1'b0;
          m_stab = 1'b0; m_gen = '0; m_row = '0;
        end else begin
          m_row  = nr;
          m_done = 1'b0;
          if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
              nb      = life_step(m_board, mw, mh, wrap, mrb, mrs);
              m_stab  = (nb == m_board);
              m_ext   = (nb == '0);
              m_board = nb;
              m_gen   = m_gen + 16'd1;
              m_done  = 1'b1;
            end
          end else if (step_req) begin
            m_left = mw * mh + 1;
          end else if (flip_req) begin
            if (int'(flip_x) < mw && int'(flip_y) < mh)
              m_board[int'(flip_y) * mw + int'(flip_x)] = ~m_board[int'(flip_y) * mw + int'(flip_x)];
          end else if (load_valid) begin
            for (int i = 0; i < mw * mh - 1; i++) m_board[i] = m_board[i + 1];
            m_board[mw * mh - 1] = load_bit;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("row", {56'd0, d_row}, {56'd0, m_row});
        chk("busy", {63'd0, d_busy}, {63'd0, m_left > 0});
        chk("done", {63'd0, d_done}, {63'd0, m_done});
        chk("gen_cnt", {48'd0, d_gen}, {48'd0, m_gen});
        chk("extinct", {63'd0, d_ext}, {63'd0, m_ext});
        chk("stable", {63'd0, d_stab}, {63'd0, m_stab});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input bit s6);
    @(negedge clk);
    cmp_en = 1'b0;
    rst = 1'b0; step_req = 1'b0; flip_req = 1'b0; load_valid = 1'b0;
    load_bit = 1'b0; row_sel = '0; wrap = 1'b0; flip_x = '0; flip_y = '0;
    sel6 = s6;
    mw  = s6 ? 6 : 8;
    mh  = s6 ? 5 : 8;
    mrb = s6 ? 9'h008 : 9'b000001000;
    mrs = s6 ? 9'h000 : 9'b000001100;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic do_flip(input int x, input int y);
    flip_x = 3'(x); flip_y = 3'(y); flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
  endtask

  task automatic load_board(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_bit = b[i];
      @(negedge clk);
    end
    load_valid = 1'b0; load_bit = 1'b0;
  endtask

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int r = 0; r < mh; r++) begin
      row_sel = 3'(r);
      @(negedge clk);
      for (int i = 0; i < mw; i++) b[r * mw + i] = d_row[i];
    end
    row_sel = '0;
  endtask

  task automatic do_step(input bit interfere, output int bc, output int dc);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    bc = 0; dc = 0;
    for (int k = 0; k < 300; k++) begin
      if (d_busy) bc++;
      if (d_done) dc++;
      if (!d_busy && dc > 0) break;
      if (interfere && d_busy) begin
        step_req = 1'b1; flip_req = 1'b1; flip_x = '0; flip_y = '0;
        load_valid = 1'b1; load_bit = 1'b1;
      end
      @(negedge clk);
      step_req = 1'b0; flip_req = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    end
    step_req = 1'b0; flip_req = 1'b0; load_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] b, g;
    int bc, dc;
    rst = 1'b0; wrap = 1'b0; step_req = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    flip_req = 1'b0; flip_x = '0; flip_y = '0; row_sel = '0;

    g = GLIDER0;
    for (int s = 0; s < 4; s++) g = life_step(g, 8, 8, 1'b1, 9'b000001000, 9'b000001100);
    chk("model_glider4", g, GLIDER4);
    chk("model_blinker", life_step(BLINK_V, 8, 8, 1'b1, 9'b000001000, 9'b000001100), BLINK_H);
    chk("model_b3s", life_step(SMALL_BL, 6, 5, 1'b0, 9'h008, 9'h000), SMALL_G1);

    // 1: blinker flips to horizontal
    do_reset(1'b0);
    wrap = 1'b1;
    load_board(BLINK_V, 64);
    read_board(b);
    chk("t1_loaded", b, BLINK_V);
    do_step(1'b0, bc, dc);
    chk("t1_busy_cycles", 64'(bc), 64'd65);
    chk("t1_done_count", 64'(dc), 64'd1);
    read_board(b);
    chk("t1_board", b, BLINK_H);
    chk("t1_gen", {48'd0, d_gen}, 64'd1);

    // 2: glider on the torus returns home after 32 generations
    do_reset(1'b0);
    wrap = 1'b1;
    load_board(GLIDER0, 64);
    for (int s = 1; s <= 32; s++) begin
      do_step(1'b0, bc, dc);
      if (s == 4) begin
        read_board(b);
        chk("t2_glider4", b, GLIDER4);
      end
    end
    read_board(b);
    chk("t2_board", b, GLIDER0);
    chk("t2_gen", {48'd0, d_gen}, 64'd32);
    chk("t2_extinct", {63'd0, d_ext}, 64'd0);
    chk("t2_stable", {63'd0, d_stab}, 64'd0);

    // 3: still lifes, open edges then wrapped corners
    do_reset(1'b0);
    wrap = 1'b0;
    load_board(BLOCK0, 64);
    do_step(1'b0, bc, dc);
    read_board(b);
    chk("t3_block", b, BLOCK0);
    chk("t3_stable", {63'd0, d_stab}, 64'd1);
    do_flip(1, 0); do_flip(0, 1); do_flip(1, 1);
    do_flip(7, 7); do_flip(0, 7); do_flip(7, 0);
    wrap = 1'b1;
    do_step(1'b0, bc, dc);
    read_board(b);
    chk("t3_corners", b, CORNERS);
    chk("t3_corner_stable", {63'd0, d_stab}, 64'd1);

    // 4: lone cell dies
    do_reset(1'b0);
    do_flip(5, 5);
    read_board(b);
    chk("t4_flip", b, CELL55);
    do_step(1'b0, bc, dc);
    read_board(b);
    chk("t4_board", b, 64'd0);
    chk("t4_extinct", {63'd0, d_ext}, 64'd1);

    // 5: 6x5 B3/S board, out-of-range edits, requests while busy
    do_reset(1'b1);
    wrap = 1'b0;
    do_flip(7, 1); do_flip(2, 5);
    read_board(b);
    chk("t5_oob_flip", b, 64'd0);
    do_flip(2, 1); do_flip(2, 2); do_flip(2, 3);
    read_board(b);
    chk("t5_blinker", b, SMALL_BL);
    row_sel = 3'd6;
    @(negedge clk);
    chk("t5_row_oob", {56'd0, d_row}, 64'd0);
    row_sel = '0;
    do_step(1'b1, bc, dc);
    chk("t5_busy_cycles", 64'(bc), 64'd31);
    chk("t5_done_count", 64'(dc), 64'd1);
    read_board(b);
    chk("t5_gen1", b, SMALL_G1);
    do_step(1'b0, bc, dc);
    read_board(b);
    chk("t5_gen2", b, 64'd0);
    chk("t5_extinct", {63'd0, d_ext}, 64'd1);
    do_flip(5, 2); do_flip(0, 2); do_flip(1, 2);
    wrap = 1'b1;
    do_step(1'b0, bc, dc);
    read_board(b);
    chk("t5_wrap", b, SMALL_WR);
    chk("t5_gen", {48'd0, d_gen}, 64'd3);

    // 6: reset in the middle of COMPUTE
    do_reset(1'b0);
    wrap = 1'b1;
    load_board(BLINK_V, 64);
    do_step(1'b0, bc, dc);
    row_sel = 3'd3;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", {63'd0, d_busy}, 64'd0);
    chk("t6_row", {56'd0, d_row}, 64'd0);
    chk("t6_gen", {48'd0, d_gen}, 64'd0);
    rst = 1'b1;
    dc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_done) dc++;
    end
    chk("t6_no_done", 64'(dc), 64'd0);
    read_board(b);
    chk("t6_board", b, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
